// File: rtl/riscv_pkg.sv
// Types and widths shared by fetch, decode and the branch unit.
`timescale 1ns/1ps
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with registered head; flush beats push and pop.
`timescale 1ns/1ps
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  fetch_entry_t     i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_entry_t     o_data,
    output logic [CNT_W-1:0] o_count,
    output logic             o_empty,
    output logic             o_full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with credit-limited issue, in-order response
// buffering and redirect squash of all in-flight and buffered fetches.
`timescale 1ns/1ps
module fetch_unit
    import riscv_pkg::fetch_entry_t;
#(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [PC_W-1:0] req_addr,
    input  logic            resp_valid,
    input  logic [31:0]     resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [PC_W-1:0] out_pc
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_hold_pc;
    logic [PC_W-1:0]  r_resp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_kill;
    logic             r_stale;

    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fifo_full;
    logic [CNT_W:0]   w_credit_used;
    logic             w_accept;
    logic             w_resp;
    logic             w_push;
    logic             w_pop;
    logic [PC_W-1:0]  w_target;
    logic [CNT_W-1:0] w_inflight_next;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    assign w_credit_used   = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign req_valid       = !rst && (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    // A request presented before a redirect keeps its address until accepted.
    assign req_addr        = r_stale ? r_hold_pc : r_pc;
    assign w_accept        = req_valid && req_ready;
    // With nothing outstanding, a response can only be left over from before reset.
    assign w_resp          = resp_valid && (r_outstanding != '0);
    assign w_push          = w_resp && !redirect_valid && (r_kill == '0) && !w_fifo_full;
    assign w_pop           = out_valid && out_ready;
    assign w_target        = redirect_pc & ~PC_W'(3);
    assign w_inflight_next = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_resp);

    // Live responses are strictly sequential from the last redirect target,
    // so the PC of the next pushed word is tracked rather than queued.
    assign w_push_entry = '{instr: resp_data, pc: r_resp_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_hold_pc     <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_kill        <= '0;
            r_stale       <= 1'b0;
        end else begin
            r_outstanding <= w_inflight_next;
            if (redirect_valid) begin
                r_pc      <= w_target;
                r_resp_pc <= w_target;
                r_kill    <= w_inflight_next;
                if (req_valid && !req_ready) begin
                    r_stale   <= 1'b1;
                    r_hold_pc <= req_addr;
                end else begin
                    r_stale   <= 1'b0;
                end
            end else begin
                r_kill <= r_kill - CNT_W'(w_resp && (r_kill != '0))
                                 + CNT_W'(w_accept && r_stale);
                if (w_accept) begin
                    if (r_stale) r_stale <= 1'b0;
                    else         r_pc    <= r_pc + PC_W'(4);
                end
                if (w_push) r_resp_pc <= r_resp_pc + PC_W'(4);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign out_valid = !w_fifo_empty;
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random-latency memory, queue-based fetch-stream model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          DEPTH   = 2;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, redirect_valid, req_ready, resp_valid, out_ready;
    logic [31:0] redirect_pc, resp_data;
    logic        req_valid, out_valid;
    logic [31:0] req_addr, out_instr, out_pc;

    logic        w_req_valid, w_out_valid, w_resp_valid;
    logic [31:0] w_req_addr, w_out_instr, w_out_pc, w_resp_data;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    fetch_unit #(.RESET_PC(WRAP_PC)) dut_w (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .req_valid      (w_req_valid),
        .req_ready      (1'b1),
        .req_addr       (w_req_addr),
        .resp_valid     (w_resp_valid),
        .resp_data      (w_resp_data),
        .out_valid      (w_out_valid),
        .out_ready      (1'b1),
        .out_instr      (w_out_instr),
        .out_pc         (w_out_pc)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Fixed one-cycle memory for the wrap-around instance.
    always @(posedge clk) begin
        w_resp_valid <= !rst && w_req_valid;
        w_resp_data  <= instr_of(w_req_addr);
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Memory model: accepted addresses with the cycle their response is due.
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    int          last_due = -1;
    int          lat_min  = 1;
    int          lat_max  = 1;

    // Fetch-stream model: in-flight requests (with liveness), expected output queue.
    logic        inf_live_q[$];
    logic [31:0] inf_addr_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] m_pc        = 32'h0;
    logic        m_pend      = 1'b0;
    logic        m_pend_dead = 1'b0;
    logic [31:0] m_pend_addr = 32'h0;

    logic [31:0] w_exp [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    int          w_seen     = 0;
    logic        w_armed    = 1'b0;
    logic        w_out_seen = 1'b0;

    task automatic step(input logic rr, input logic orr, input logic rv,
                        input logic [31:0] rpc, input logic rs);
        logic        rq_v, o_v, rsp, live, exp_rv;
        logic [31:0] rq_a, rsp_addr, ea;
        int          due;
        @(negedge clk);
        rst = rs; req_ready = rr; out_ready = orr;
        redirect_valid = rv; redirect_pc = rpc;
        rsp = 1'b0; rsp_addr = 32'h0;
        if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
            rsp = 1'b1;
            rsp_addr = mem_addr_q.pop_front();
            void'(mem_due_q.pop_front());
        end
        resp_valid = rsp;
        resp_data  = rsp ? instr_of(rsp_addr) : $urandom;
        #1;
        rq_v = req_valid; rq_a = req_addr; o_v = out_valid;
        ea = m_pend ? m_pend_addr : m_pc;
        exp_rv = !rs && ((exp_q.size() + inf_live_q.size()) < DEPTH);
        check("req_valid", 64'(rq_v), 64'(exp_rv));
        if (rq_v && exp_rv) check("req_addr", 64'(rq_a), 64'(ea));
        check("out_valid", 64'(o_v), 64'(exp_q.size() != 0));
        if (o_v && exp_q.size() != 0) begin
            check("out_pc", 64'(out_pc), 64'(exp_q[0][31:0]));
            check("out_instr", 64'(out_instr), 64'(exp_q[0][63:32]));
        end
        if (w_armed && !rs && w_req_valid && w_seen < 3) begin
            check("wrap_addr", 64'(w_req_addr), 64'(w_exp[w_seen]));
            w_seen++;
        end
        if (w_armed && !rs && w_out_valid && !w_out_seen) begin
            check("wrap_out_pc", 64'(w_out_pc), 64'(WRAP_PC));
            check("wrap_out_instr", 64'(w_out_instr), 64'(instr_of(WRAP_PC)));
            w_out_seen = 1'b1;
        end

        @(posedge clk);
        cyc++;
        if (rs) begin
            inf_live_q.delete(); inf_addr_q.delete(); exp_q.delete();
            m_pc = 32'h0; m_pend = 1'b0; m_pend_dead = 1'b0;
        end else begin
            if (o_v && orr && !rv && exp_q.size() != 0) void'(exp_q.pop_front());
            if (rsp && inf_live_q.size() > 0) begin
                live = inf_live_q.pop_front();
                ea   = inf_addr_q.pop_front();
                if (live && !rv) begin
                    check("no_overflow", 64'(exp_q.size() < DEPTH), 64'(1));
                    exp_q.push_back({instr_of(ea), ea});
                end
            end
            ea = m_pend ? m_pend_addr : m_pc;
            if (rq_v && rr) begin
                due = cyc + $urandom_range(lat_min, lat_max) - 1;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_addr_q.push_back(rq_a);
                mem_due_q.push_back(due);
                live = !(m_pend && m_pend_dead);
                inf_live_q.push_back(live);
                inf_addr_q.push_back(ea);
                if (live) m_pc = ea + 32'd4;
                m_pend = 1'b0; m_pend_dead = 1'b0;
            end else if (rq_v && !m_pend) begin
                m_pend = 1'b1; m_pend_addr = ea; m_pend_dead = 1'b0;
            end
            if (rv) begin
                foreach (inf_live_q[i]) inf_live_q[i] = 1'b0;
                exp_q.delete();
                m_pc = rpc & ~32'd3;
                if (m_pend) m_pend_dead = 1'b1;
            end
        end
    endtask

    // Reset, then hold off new requests until leftover responses have drained.
    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        w_armed = 1'b1;
        for (int i = 0; i < 10 && mem_addr_q.size() > 0; i++)
            step(1'b0, ($urandom_range(0, 1) == 1), 1'b0, 32'h0, 1'b0);
        if (mem_addr_q.size() > 0) check("mem_drain", 64'(mem_addr_q.size()), 64'(0));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = 32'h0; out_ready = 1'b0;

        // Streaming with a one-cycle memory
        lat_min = 1; lat_max = 1;
        do_reset();
        repeat (30) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        // Decode stall then release
        repeat (10) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        // Two outstanding at 0x10/0x14, then redirect to 0x100
        lat_min = 3; lat_max = 3;
        step(1'b1, 1'b1, 1'b1, 32'h10, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h100, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        // Redirect to unaligned 0x203 in the same cycle 0x20 is accepted
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 1'b1, 32'h20, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h203, 1'b0);
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        // Pending request at 0x40 redirected to 0x80 before acceptance
        step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        // Address wrap via redirect
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF4, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        // Reset mid-stream with requests outstanding
        lat_min = 3; lat_max = 3;
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        // Randomized traffic
        for (int blk = 0; blk < 15; blk++) begin
            int rr_pct;
            int or_pct;
            lat_min = 1;
            lat_max = $urandom_range(1, 4);
            rr_pct  = $urandom_range(30, 100);
            or_pct  = $urandom_range(20, 100);
            for (int i = 0; i < 200; i++) begin
                logic        rr, orr, rv;
                logic [31:0] rpc;
                rr  = ($urandom_range(1, 100) <= rr_pct);
                orr = ($urandom_range(1, 100) <= or_pct);
                rv  = ($urandom_range(0, 15) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : 32'($urandom);
                if ($urandom_range(0, 499) == 0) do_reset();
                else step(rr, orr, rv, rpc, 1'b0);
            end
        end

        check("wrap_seen", 64'(w_seen), 64'(3));
        check("wrap_out_seen", 64'(w_out_seen), 64'(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
